screen_mux: RTL and testbench
=============================

# screen_mux

Parametrised, frame-synchronous output selector for the snake video path. It picks one of `N_SRC` screen renderers (menu, error, win/lose/draw, game, …) by `sel`, or falls back to the raw timing input. Switching happens only on frame boundaries, with an optional per-frame brightness fade-out and fade-in. It sits between the per-screen draw submodules and the VGA output register stage, and replaces the fixed one-hot-by-mode output mux.

## Interface
Parameters:
- `N_SRC`, 6: number of renderer sources.
- `SEL_W`, 3: width of `sel`; must satisfy 2^SEL_W > N_SRC.
- `RGB_B`, 12: pixel width; three equal components of RGB_B/3 bits.
- `FADE_SH`, 3: fade depth; full level `LVL_MAX` = 2^FADE_SH (8 frames each direction).
- `FADE_EN`, 1: 0 = hard cut at frame boundary, 1 = fade out/in.
- `RST_SEL`, 0: active source after reset.
- `FALLBACK_RGB`, 12'h0F0: colour driven when the fallback path is active.

Ports:
- `clk`, in, 1: pixel clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `sel`, in, SEL_W: requested source; a value ≥ N_SRC selects fallback.
- `src_hcount`, `src_vcount`, in, N_SRC×11 (packed, source i at [11i+10:11i]): renderer counters.
- `src_hblnk`, `src_vblnk`, `src_hsync`, `src_vsync`, in, N_SRC: renderer timing flags.
- `src_rgb`, in, N_SRC×RGB_B: renderer pixels.
- `in_hcount`, `in_vcount`, in, 11: fallback counters.
- `in_hblnk`, `in_vblnk`, `in_hsync`, `in_vsync`, in, 1: fallback timing flags.
- `out_hcount`, `out_vcount`, out, 11: registered selected counters.
- `out_hblnk`, `out_vblnk`, `out_hsync`, `out_vsync`, out, 1: registered selected flags.
- `rgb`, out, RGB_B: registered, faded pixel.
- `active_sel`, out, SEL_W: index currently on screen; N_SRC = fallback.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- Index normalisation: `tgt` = sel if sel < N_SRC, else N_SRC.
- Path N_SRC: timing comes from `in_*`; pixel is FALLBACK_RGB.
- Frame boundary `fb`: rising edge of the active path's vblnk, using a 1-cycle delayed copy. `fb` is suppressed on the cycle after `active_sel` changes, so a source swap cannot create a false edge.
- Fade level `lvl` ranges 0..LVL_MAX.
  - Each component: c_out = (c × lvl) >> FADE_SH, with an intermediate width of RGB_B/3 + FADE_SH + 1.
  - lvl = LVL_MAX is exact pass-through; lvl = 0 is black.
- Blanking: when the selected hblnk | vblnk is high, rgb = 0 regardless of lvl.
- FSM:
  - IDLE: lvl = LVL_MAX. If tgt ≠ active_sel, go to FADE_OUT (FADE_EN=1) or CUT (FADE_EN=0).
  - CUT: on `fb`, active_sel ← tgt, go to IDLE.
  - FADE_OUT: on `fb`:
    - If tgt = active_sel (request withdrawn), go to FADE_IN.
    - Else if lvl = 0, active_sel ← tgt and go to FADE_IN.
    - Else lvl ← lvl − 1.
  - FADE_IN: on `fb`:
    - If tgt ≠ active_sel, go to FADE_OUT.
    - Else lvl ← lvl + 1; on reaching LVL_MAX, go to IDLE.
- `tgt` is re-evaluated every cycle, so sel may change mid-fade with no lost request. A newer request overrides an older pending one.
- `sel` toggling and returning within one frame in IDLE/CUT: no visible effect, because CUT re-checks tgt at `fb`.

## Timing
- Reset (asynchronous assert, synchronous deassert):
  - all out_* = 0, rgb = 0, busy = 0.
  - active_sel = RST_SEL, lvl = LVL_MAX, FSM = IDLE.
- Latency: every output is 1 clock after its source inputs. Counters, syncs and rgb stay mutually aligned; there is no extra delay on any path.
- Source switch takes effect on the first pixel of the frame following `fb`. Counters and syncs never switch mid-line.
- Full fade transition takes 2 × LVL_MAX + 1 frame boundaries. A hard cut takes ≤ 1 frame.
- Reset mid-fade: instantly restores RST_SEL at full brightness.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0; release with sel=0 → after 1 clk, out_* and rgb equal source 0 delayed by 1 clk; busy=0.
- Hard cut (FADE_EN=0): sel 0→3 mid-frame → outputs stay on source 0 until vblnk rise, then source 3; active_sel=3 from that cycle+1.
- Fade (FADE_EN=1, FADE_SH=3, src rgb=12'hFFF):
  - rgb per frame is F,D,B,9,7,5,3,1,0 per nibble (levels 8..0), then source switches.
  - rgb then ramps 0→F; busy is low after 17 boundaries.
- Reversal: start FADE_OUT, withdraw request at lvl=5 → next boundary enters FADE_IN, lvl 6,7,8, active_sel unchanged.
- Out of range: sel=7 with N_SRC=6 → timing follows in_*, rgb=12'h0F0 when unblanked and 0 in blanking, active_sel=6.
- Blanking: src_rgb=12'hABC with hblnk=1 → rgb=0 at any lvl.

Source files
------------

// File: rtl/screen_mux_if.sv
// screen_mux_if: registered video output bus of the screen selector
interface screen_mux_if #(
    parameter int RGB_B = 12
);
    logic [10:0]      out_hcount;
    logic [10:0]      out_vcount;
    logic             out_hblnk;
    logic             out_vblnk;
    logic             out_hsync;
    logic             out_vsync;
    logic [RGB_B-1:0] rgb;
    modport master (output out_hcount, out_vcount, out_hblnk, out_vblnk, out_hsync, out_vsync, rgb);
    modport slave (input out_hcount, out_vcount, out_hblnk, out_vblnk, out_hsync, out_vsync, rgb);
endinterface

// File: rtl/screen_mux.sv
// screen_mux: frame-synchronous renderer selector with fallback path and optional
// per-frame brightness fade between sources.
module screen_mux #(
    parameter int               N_SRC        = 6,
    parameter int               SEL_W        = 3,
    parameter int               RGB_B        = 12,
    parameter int               FADE_SH      = 3,
    parameter bit               FADE_EN      = 1'b1,
    parameter int               RST_SEL      = 0,
    parameter logic [RGB_B-1:0] FALLBACK_RGB = 12'h0F0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_SRC*11-1:0]    src_hcount,
    input  logic [N_SRC*11-1:0]    src_vcount,
    input  logic [N_SRC-1:0]       src_hblnk,
    input  logic [N_SRC-1:0]       src_vblnk,
    input  logic [N_SRC-1:0]       src_hsync,
    input  logic [N_SRC-1:0]       src_vsync,
    input  logic [N_SRC*RGB_B-1:0] src_rgb,
    input  logic [10:0]            in_hcount,
    input  logic [10:0]            in_vcount,
    input  logic                   in_hblnk,
    input  logic                   in_vblnk,
    input  logic                   in_hsync,
    input  logic                   in_vsync,
    screen_mux_if.master           vid,
    output logic [SEL_W-1:0]       active_sel,
    output logic                   busy
);
    localparam int C_W = RGB_B / 3;
    localparam int P_W = C_W + FADE_SH + 1;
    localparam logic [FADE_SH:0] LVL_MAX = {1'b1, {FADE_SH{1'b0}}};
    localparam logic [FADE_SH:0] LVL_ONE = {{FADE_SH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, CUT, FADE_OUT, FADE_IN} state_t;

    state_t                       state, state_n;
    logic [FADE_SH:0]             lvl, lvl_n;
    logic [SEL_W-1:0]             tgt, act_n;
    logic                         swapped, fb;
    logic [(N_SRC+1)*11-1:0]      all_hc, all_vc;
    logic [N_SRC:0]               all_hb, all_vb, all_hs, all_vs;
    logic [(N_SRC+1)*RGB_B-1:0]   all_rgb;
    logic [RGB_B-1:0]             pix, faded;

    // The fallback path sits at index N_SRC, so one index serves every path.
    assign all_hc  = {in_hcount, src_hcount};
    assign all_vc  = {in_vcount, src_vcount};
    assign all_hb  = {in_hblnk, src_hblnk};
    assign all_vb  = {in_vblnk, src_vblnk};
    assign all_hs  = {in_hsync, src_hsync};
    assign all_vs  = {in_vsync, src_vsync};
    assign all_rgb = {FALLBACK_RGB, src_rgb};

    assign tgt  = (sel < SEL_W'(N_SRC)) ? sel : SEL_W'(N_SRC);
    assign pix  = all_rgb[int'(active_sel)*RGB_B +: RGB_B];
    // out_vblnk is the delayed copy of the active vblnk; ignore it right after a swap.
    assign fb   = all_vb[active_sel] & ~vid.out_vblnk & ~swapped;
    assign busy = state != IDLE;

    always_comb begin
        faded = '0;
        for (int i = 0; i < 3; i++)
            faded[i*C_W +: C_W] = C_W'((P_W'(pix[i*C_W +: C_W]) * P_W'(lvl)) >> FADE_SH);
    end

    always_comb begin
        state_n = state;
        lvl_n   = lvl;
        act_n   = active_sel;
        case (state)
            IDLE: begin
                lvl_n = LVL_MAX;
                if (tgt != active_sel) state_n = FADE_EN ? FADE_OUT : CUT;
            end
            CUT: if (fb) begin
                act_n   = tgt;
                state_n = IDLE;
            end
            FADE_OUT: if (fb) begin
                if (tgt == active_sel) state_n = FADE_IN;
                else if (lvl == '0) begin
                    act_n   = tgt;
                    state_n = FADE_IN;
                end else lvl_n = lvl - LVL_ONE;
            end
            default: if (fb) begin
                if (tgt != active_sel) state_n = FADE_OUT;
                else begin
                    // a request withdrawn before any dimming re-enters here already at full level
                    lvl_n   = (lvl == LVL_MAX) ? lvl : lvl + LVL_ONE;
                    state_n = (lvl_n == LVL_MAX) ? IDLE : FADE_IN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            lvl            <= LVL_MAX;
            active_sel     <= SEL_W'(RST_SEL);
            swapped        <= 1'b0;
            vid.out_hcount <= '0;
            vid.out_vcount <= '0;
            vid.out_hblnk  <= 1'b0;
            vid.out_vblnk  <= 1'b0;
            vid.out_hsync  <= 1'b0;
            vid.out_vsync  <= 1'b0;
            vid.rgb        <= '0;
        end else begin
            state          <= state_n;
            lvl            <= lvl_n;
            active_sel     <= act_n;
            swapped        <= act_n != active_sel;
            vid.out_hcount <= all_hc[int'(active_sel)*11 +: 11];
            vid.out_vcount <= all_vc[int'(active_sel)*11 +: 11];
            vid.out_hblnk  <= all_hb[active_sel];
            vid.out_vblnk  <= all_vb[active_sel];
            vid.out_hsync  <= all_hs[active_sel];
            vid.out_vsync  <= all_vs[active_sel];
            vid.rgb        <= (all_hb[active_sel] | all_vb[active_sel]) ? '0 : faded;
        end
    end
endmodule

// File: tb/tb_screen_mux.sv
// tb_screen_mux: random and directed checks of a fading and a hard-cut screen_mux
// against a frame-level behavioural model.
module tb_screen_mux;
    localparam int N = 6, SW = 3, RB = 12, FRAME = 96;

    logic clk = 1'b0, rst = 1'b1;
    logic [SW-1:0] sel;
    logic [N*11-1:0] src_hcount, src_vcount;
    logic [N-1:0] src_hblnk, src_vblnk, src_hsync, src_vsync;
    logic [N*RB-1:0] src_rgb;
    logic [10:0] in_hcount, in_vcount;
    logic in_hblnk, in_vblnk, in_hsync, in_vsync;
    logic [SW-1:0] act_f, act_c;
    logic busy_f, busy_c;

    screen_mux_if #(.RGB_B(RB)) vid_f ();
    screen_mux_if #(.RGB_B(RB)) vid_c ();

    screen_mux #(.FADE_EN(1'b1)) u_fade (
        .clk(clk), .rst(rst), .sel(sel),
        .src_hcount(src_hcount), .src_vcount(src_vcount),
        .src_hblnk(src_hblnk), .src_vblnk(src_vblnk), .src_hsync(src_hsync), .src_vsync(src_vsync),
        .src_rgb(src_rgb), .in_hcount(in_hcount), .in_vcount(in_vcount),
        .in_hblnk(in_hblnk), .in_vblnk(in_vblnk), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .vid(vid_f), .active_sel(act_f), .busy(busy_f));

    screen_mux #(.FADE_EN(1'b0)) u_cut (
        .clk(clk), .rst(rst), .sel(sel),
        .src_hcount(src_hcount), .src_vcount(src_vcount),
        .src_hblnk(src_hblnk), .src_vblnk(src_vblnk), .src_hsync(src_hsync), .src_vsync(src_vsync),
        .src_rgb(src_rgb), .in_hcount(in_hcount), .in_vcount(in_vcount),
        .in_hblnk(in_hblnk), .in_vblnk(in_vblnk), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .vid(vid_c), .active_sel(act_c), .busy(busy_c));

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int h, v;
    bit flat;
    logic [RB-1:0] fill;
    logic [10:0] t_hc [N+1], t_vc [N+1];
    logic t_hb [N+1], t_vb [N+1], t_hs [N+1], t_vs [N+1];
    logic [RB-1:0] t_rgb [N+1];
    logic [3:0] probe_q [$];

    // model: index 0 is the fading instance, 1 the hard-cut instance
    int m_act [2], m_lvl [2];
    bit m_busy [2], m_down [2], m_sw [2], m_pvb [2];
    logic [10:0] e_hc [2], e_vc [2];
    logic [3:0] e_fl [2];
    logic [RB-1:0] e_rgb [2];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [RB-1:0] scale(logic [RB-1:0] c, int l);
        logic [RB-1:0] r;
        for (int i = 0; i < 3; i++) r[i*4 +: 4] = 4'((int'(c[i*4 +: 4]) * l) / 8);
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i <= N; i++) begin
            t_hc[i]  = 11'(h + 32*i);
            t_vc[i]  = 11'(v + 64*i);
            t_hb[i]  = h >= 12 - i;
            t_vb[i]  = v >= 4;
            t_hs[i]  = 1'($urandom);
            t_vs[i]  = 1'($urandom);
            t_rgb[i] = (i == N) ? 12'h0F0 : flat ? fill : RB'($urandom);
        end
        for (int i = 0; i < N; i++) begin
            src_hcount[i*11 +: 11] = t_hc[i];
            src_vcount[i*11 +: 11] = t_vc[i];
            src_hblnk[i] = t_hb[i];
            src_vblnk[i] = t_vb[i];
            src_hsync[i] = t_hs[i];
            src_vsync[i] = t_vs[i];
            src_rgb[i*RB +: RB] = t_rgb[i];
        end
        in_hcount = t_hc[N];
        in_vcount = t_vc[N];
        in_hblnk  = t_hb[N];
        in_vblnk  = t_vb[N];
        in_hsync  = t_hs[N];
        in_vsync  = t_vs[N];
    endtask

    task automatic advance();
        h = (h == 15) ? 0 : h + 1;
        if (h == 0) v = (v == 5) ? 0 : v + 1;
        drive();
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_lvl[k] = 8;
            m_busy[k] = 1'b0; m_down[k] = 1'b0; m_sw[k] = 1'b0; m_pvb[k] = 1'b0;
        end
    endtask

    task automatic model_step(int k);
        int a, t, na;
        bit fb;
        a  = m_act[k];
        t  = (int'(sel) < N) ? int'(sel) : N;
        fb = t_vb[a] && !m_pvb[k] && !m_sw[k];
        e_hc[k]  = t_hc[a];
        e_vc[k]  = t_vc[a];
        e_fl[k]  = {t_hb[a], t_vb[a], t_hs[a], t_vs[a]};
        e_rgb[k] = (t_hb[a] || t_vb[a]) ? '0 : scale(t_rgb[a], m_lvl[k]);
        na = a;
        if (!m_busy[k]) begin
            if (t != a) begin m_busy[k] = 1'b1; m_down[k] = 1'b1; end
        end else if (fb) begin
            if (k == 1) begin na = t; m_busy[k] = 1'b0; end
            else if (m_down[k]) begin
                if (t == a) m_down[k] = 1'b0;
                else if (m_lvl[k] == 0) begin na = t; m_down[k] = 1'b0; end
                else m_lvl[k]--;
            end else if (t != a) m_down[k] = 1'b1;
            else begin
                if (m_lvl[k] < 8) m_lvl[k]++;
                if (m_lvl[k] == 8) m_busy[k] = 1'b0;
            end
        end
        m_sw[k]  = na != a;
        m_pvb[k] = t_vb[a];
        m_act[k] = na;
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check("vid_f", {vid_f.out_hcount, vid_f.out_vcount, vid_f.out_hblnk, vid_f.out_vblnk,
                        vid_f.out_hsync, vid_f.out_vsync}, {e_hc[0], e_vc[0], e_fl[0]});
        check("rgb_f", vid_f.rgb, e_rgb[0]);
        check("ctl_f", {act_f, busy_f}, {SW'(m_act[0]), m_busy[0]});
        check("vid_c", {vid_c.out_hcount, vid_c.out_vcount, vid_c.out_hblnk, vid_c.out_vblnk,
                        vid_c.out_hsync, vid_c.out_vsync}, {e_hc[1], e_vc[1], e_fl[1]});
        check("rgb_c", vid_c.rgb, e_rgb[1]);
        check("ctl_c", {act_c, busy_c}, {SW'(m_act[1]), m_busy[1]});
        if (probe_q.size() > 0 && h == 2 && v == 1) begin
            logic [3:0] nib;
            nib = probe_q.pop_front();
            check("fade_lvl", vid_f.rgb, {nib, nib, nib});
        end
        advance();
    endtask

    task automatic reset_phase(int cycles, logic [SW-1:0] rel);
        rst = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            check("rst_f", {vid_f.out_hcount, vid_f.out_vcount, vid_f.out_hblnk, vid_f.out_vblnk,
                            vid_f.out_hsync, vid_f.out_vsync, vid_f.rgb, act_f, busy_f}, '0);
            check("rst_c", {vid_c.out_hcount, vid_c.out_vcount, vid_c.out_hblnk, vid_c.out_vblnk,
                            vid_c.out_hsync, vid_c.out_vsync, vid_c.rgb, act_c, busy_c}, '0);
            sel = SW'($urandom);
            @(posedge clk);
            #1;
            advance();
        end
        sel = rel;
        rst = 1'b1;
    endtask

    task automatic goto(int hh, int vv);
        for (int i = 0; i < 2*FRAME && !(h == hh && v == vv); i++) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] fade_tbl [18] = '{4'hF, 4'hD, 4'hB, 4'h9, 4'h7, 4'h5, 4'h3, 4'h1, 4'h0,
                                      4'h0, 4'h1, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF};
        logic [3:0] rev_tbl [8] = '{4'hF, 4'hD, 4'hB, 4'h9, 4'h9, 4'hB, 4'hD, 4'hF};
        sel = '0; h = 0; v = 0; flat = 1'b0; fill = '0;
        drive();
        reset_phase(4, '0);
        repeat (2*FRAME) step();
        // full fade 0 -> 3 on white sources, probed once per frame
        flat = 1'b1; fill = 12'hFFF;
        goto(0, 0);
        foreach (fade_tbl[i]) probe_q.push_back(fade_tbl[i]);
        sel = 3'd3;
        repeat (18*FRAME) step();
        check("fade_busy", busy_f, 1'b0);
        check("fade_act", act_f, 3'd3);
        check("cut_act", act_c, 3'd3);
        // request 1 withdrawn once the level has dropped to 5
        foreach (rev_tbl[i]) probe_q.push_back(rev_tbl[i]);
        sel = 3'd1;
        repeat (3*FRAME) step();
        sel = 3'd3;
        repeat (5*FRAME) step();
        check("rev_act", act_f, 3'd3);
        check("rev_busy", busy_f, 1'b0);
        check("probe_left", probe_q.size(), 0);
        // out-of-range request falls back to the timing input
        flat = 1'b0; sel = 3'd7;
        repeat (20*FRAME) step();
        check("oor_act_f", act_f, 3'd6);
        check("oor_act_c", act_c, 3'd6);
        goto(2, 1); step();
        check("oor_rgb", vid_f.rgb, 12'h0F0);
        check("oor_hc", vid_f.out_hcount, 11'd194);
        goto(13, 1); step();
        check("oor_blank", vid_f.rgb, 12'h000);
        // blanking dominates at any fade level
        flat = 1'b1; fill = 12'hABC; sel = 3'd0;
        repeat (20*FRAME) step();
        goto(0, 0);
        sel = 3'd2;
        goto(12, 1); step();
        check("blank_l8", vid_f.rgb, 12'h000);
        goto(2, 1); step();
        check("abc_l7", vid_f.rgb, 12'h89A);
        goto(12, 1); step();
        check("blank_l7", vid_f.rgb, 12'h000);
        repeat (20*FRAME) step();
        // random requests, with one reset landing mid-transition
        flat = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) sel = SW'($urandom_range(0, 7));
            if (i == 1400) sel = (m_act[0] == 1) ? 3'd2 : 3'd1;
            if (i == 1500) reset_phase(3, SW'($urandom_range(0, 7)));
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
